// File: rtl/io_port_controller.sv
// -----------------------------------------------------------------------------
// io_port_controller
// Peripheral-side partner of the processor I/O interface.
//   - RX FIFO buffers words from an external device; the head is presented on
//     input_port and announced with a one-cycle interrupt pulse.
//   - TX holding register captures processor OUT writes and offers them to an
//     external consumer over a valid/ready handshake.
//
// Build option:
//   IOCTRL_IRQ_COALESCE_EN  - when defined, one interrupt pulse per batch: the
//                             FSM leaves WAIT_ACK only when a pop empties the
//                             FIFO. Undefined: one pulse per word.
//
// Ports:
//   clk, rst            clock (rising edge) / asynchronous active-low reset
//   dev_in_data/valid   word from external device
//   dev_in_ready        RX FIFO has space
//   input_port          FIFO head (0 when empty)
//   in_consume          processor retired an IN; pop the head
//   interrupt_signal    one-cycle interrupt request
//   out_port            processor output word
//   outport_enable      processor OUT strobe
//   dev_out_data/valid  TX holding register and its full flag
//   dev_out_ready       external consumer accepts
//   tx_overrun          sticky: an unsent TX word was overwritten
//   fifo_count          RX occupancy
// -----------------------------------------------------------------------------
module io_port_controller #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IRQ_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        dev_in_data,
  input  logic                     dev_in_valid,
  output logic                     dev_in_ready,
  output logic [DATA_W-1:0]        input_port,
  input  logic                     in_consume,
  output logic                     interrupt_signal,
  input  logic [DATA_W-1:0]        out_port,
  input  logic                     outport_enable,
  output logic [DATA_W-1:0]        dev_out_data,
  output logic                     dev_out_valid,
  input  logic                     dev_out_ready,
  output logic                     tx_overrun,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = (IRQ_GAP > 1) ? $clog2(IRQ_GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_GAP      = 2'd3
  } irq_state_e;

  // RX FIFO state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // IRQ FSM state
  irq_state_e        state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              irq_q, irq_d;
  logic              ack;

  // TX state
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              overrun_q, overrun_d;

  // Push/pop qualification: a full FIFO refuses the push, an empty one ignores the pop
  always_comb begin
    push = dev_in_valid && (count_q != CNT_W'(DEPTH));
    pop  = in_consume && (count_q != '0);
  end

  // FIFO pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Acknowledge condition that ends WAIT_ACK
`ifdef IOCTRL_IRQ_COALESCE_EN
  always_comb ack = pop && (count_d == '0);
`else
  always_comb ack = pop;
`endif

  // IRQ next-state; a pop outside WAIT_ACK only affects the FIFO
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(IRQ_GAP - 1)) state_d = S_IDLE;
        else                              gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so the pulse lines up exactly with the ASSERT state
    irq_d = (state_d == S_ASSERT);
  end

  // TX holding register: a new OUT wins over a same-cycle transfer
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = overrun_q;
    if (outport_enable) begin
      tx_data_d  = out_port;
      tx_valid_d = 1'b1;
      if (tx_valid_q && !dev_out_ready) overrun_d = 1'b1;
    end else if (tx_valid_q && dev_out_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // Control/status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      gap_q      <= '0;
      irq_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      irq_q      <= irq_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // FIFO storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dev_in_data;
  end

  assign dev_in_ready     = (count_q != CNT_W'(DEPTH));
  assign input_port       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign interrupt_signal = irq_q;
  assign dev_out_data     = tx_data_q;
  assign dev_out_valid    = tx_valid_q;
  assign tx_overrun       = overrun_q;
  assign fifo_count       = count_q;

endmodule

// File: tb/tb_io_port_controller.sv
// -----------------------------------------------------------------------------
// tb_io_port_controller
// Directed self-checking bench for io_port_controller (DATA_W=16, DEPTH=4,
// IRQ_GAP=2). Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_io_port_controller;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned IRQ_GAP = 2;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] dev_in_data;
  logic              dev_in_valid;
  logic              dev_in_ready;
  logic [DATA_W-1:0] input_port;
  logic              in_consume;
  logic              interrupt_signal;
  logic [DATA_W-1:0] out_port;
  logic              outport_enable;
  logic [DATA_W-1:0] dev_out_data;
  logic              dev_out_valid;
  logic              dev_out_ready;
  logic              tx_overrun;
  logic [2:0]        fifo_count;

  int total = 0;
  int bad   = 0;

  io_port_controller #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IRQ_GAP(IRQ_GAP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dev_in_data     (dev_in_data),
    .dev_in_valid    (dev_in_valid),
    .dev_in_ready    (dev_in_ready),
    .input_port      (input_port),
    .in_consume      (in_consume),
    .interrupt_signal(interrupt_signal),
    .out_port        (out_port),
    .outport_enable  (outport_enable),
    .dev_out_data    (dev_out_data),
    .dev_out_valid   (dev_out_valid),
    .dev_out_ready   (dev_out_ready),
    .tx_overrun      (tx_overrun),
    .fifo_count      (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dev_in_data    = '0;
    dev_in_valid   = 1'b0;
    in_consume     = 1'b0;
    out_port       = '0;
    outport_enable = 1'b0;
    dev_out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    step();
    rst = 1'b1;
  endtask

  // Watchdog: the bench is fully bounded, this only guards against a hang
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int last;
    int arm;
    int drain;
    int word;

    rst = 1'b1;
    idle_inputs();
    #1 rst = 1'b0;

    // T1: reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      dev_in_data    = DATA_W'($urandom);
      dev_in_valid   = 1'($urandom);
      in_consume     = 1'($urandom);
      out_port       = DATA_W'($urandom);
      outport_enable = 1'($urandom);
      dev_out_ready  = 1'($urandom);
      step();
      chk("rst_irq",     32'(interrupt_signal), 32'd0);
      chk("rst_ready",   32'(dev_in_ready),     32'd1);
      chk("rst_ovalid",  32'(dev_out_valid),    32'd0);
      chk("rst_inport",  32'(input_port),       32'd0);
      chk("rst_count",   32'(fifo_count),       32'd0);
      chk("rst_overrun", 32'(tx_overrun),       32'd0);
    end
    idle_inputs();
    rst = 1'b1;
    step();

    // T2: single word, pulse latency and consume
    dev_in_valid = 1'b1;
    dev_in_data  = 16'h1234;
    step();                                   // edge N
    dev_in_valid = 1'b0;
    chk("t2_head",   32'(input_port),       32'h1234);
    chk("t2_count1", 32'(fifo_count),       32'd1);
    chk("t2_irq_n",  32'(interrupt_signal), 32'd0);
    step();                                   // edge N+1
    chk("t2_irq_hi", 32'(interrupt_signal), 32'd1);
    step();
    chk("t2_irq_lo", 32'(interrupt_signal), 32'd0);
    in_consume = 1'b1;
    step();
    in_consume = 1'b0;
    chk("t2_count0", 32'(fifo_count), 32'd0);
    chk("t2_empty",  32'(input_port), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (interrupt_signal) pulses++;
    end
    chk("t2_no_irq", 32'(pulses), 32'd0);

    // T3: fill, then push+pop while full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dev_in_valid = 1'b1;
      dev_in_data  = DATA_W'(16'hA0 + i);
      step();
    end
    dev_in_valid = 1'b0;
    chk("t3_full_cnt", 32'(fifo_count),   32'd4);
    chk("t3_full_rdy", 32'(dev_in_ready), 32'd0);
    chk("t3_head0",    32'(input_port),   32'hA0);
    in_consume   = 1'b1;
    dev_in_valid = 1'b1;
    dev_in_data  = 16'hA4;
    step();
    dev_in_valid = 1'b0;
    in_consume   = 1'b0;
    chk("t3_cnt3",  32'(fifo_count),   32'd3);
    chk("t3_head1", 32'(input_port),   32'hA1);
    chk("t3_rdy",   32'(dev_in_ready), 32'd1);
    for (int i = 2; i < 4; i++) begin
      in_consume = 1'b1;
      step();
      chk("t3_drain", 32'(input_port), 32'(16'hA0 + i));
    end
    step();                                   // pops the last word (A3)
    in_consume = 1'b0;
    chk("t3_cnt0", 32'(fifo_count), 32'd0);

    // T4: TX handshake and overrun
    do_reset();
    outport_enable = 1'b1;
    out_port       = 16'h00FF;
    step();
    outport_enable = 1'b0;
    chk("t4_valid1", 32'(dev_out_valid), 32'd1);
    chk("t4_data1",  32'(dev_out_data),  32'h00FF);
    chk("t4_ovr0",   32'(tx_overrun),    32'd0);
    outport_enable = 1'b1;
    out_port       = 16'h0100;
    step();
    outport_enable = 1'b0;
    chk("t4_data2",  32'(dev_out_data),  32'h0100);
    chk("t4_ovr1",   32'(tx_overrun),    32'd1);
    chk("t4_valid2", 32'(dev_out_valid), 32'd1);
    dev_out_ready = 1'b1;
    step();
    chk("t4_valid0", 32'(dev_out_valid), 32'd0);
    chk("t4_sticky", 32'(tx_overrun),    32'd1);

    // T4b: transfer and new OUT in the same cycle keeps valid, no overrun
    do_reset();
    dev_out_ready  = 1'b1;
    outport_enable = 1'b1;
    out_port       = 16'h0200;
    step();
    out_port       = 16'h0300;
    step();
    outport_enable = 1'b0;
    chk("t4b_valid", 32'(dev_out_valid), 32'd1);
    chk("t4b_data",  32'(dev_out_data),  32'h0300);
    chk("t4b_ovr",   32'(tx_overrun),    32'd0);
    step();
    chk("t4b_drain", 32'(dev_out_valid), 32'd0);

    // T5: asynchronous reset while waiting for acknowledge
    do_reset();
    dev_in_valid = 1'b1;
    dev_in_data  = 16'h5A5A;
    step();
    dev_in_data  = 16'h6B6B;
    step();
    dev_in_valid = 1'b0;
    chk("t5_irq", 32'(interrupt_signal), 32'd1);
    step();                                   // now in WAIT_ACK
    chk("t5_cnt2", 32'(fifo_count), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("t5_rcnt",  32'(fifo_count),       32'd0);
    chk("t5_rirq",  32'(interrupt_signal), 32'd0);
    chk("t5_rhead", 32'(input_port),       32'd0);
    step();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (interrupt_signal) pulses++;
    end
    chk("t5_no_irq", 32'(pulses), 32'd0);

    // T6: three words, consume while in WAIT_ACK
    do_reset();
    pulses = 0;
    last   = -1;
    arm    = 0;
    drain  = 0;
    word   = 0;
    dev_in_valid = 1'b1;
    dev_in_data  = 16'hB0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      in_consume = 1'b0;
      if (cyc < 2) begin
        dev_in_data = DATA_W'(16'hB1 + cyc);
      end else begin
        dev_in_valid = 1'b0;
      end
      if (interrupt_signal) begin
        pulses++;
        if (last >= 0) chk("t6_spacing", 32'(cyc - last), 32'(IRQ_GAP + 3));
        last = cyc;
        arm  = 1;
      end else if (arm != 0) begin
        arm = 0;
`ifdef IOCTRL_IRQ_COALESCE_EN
        drain = 1;
`else
        chk("t6_head", 32'(input_port), 32'(16'hB0 + word));
        word++;
        in_consume = 1'b1;
`endif
      end
      if (drain != 0) begin
        if (fifo_count != '0) in_consume = 1'b1;
        else                  drain      = 0;
      end
    end
`ifdef IOCTRL_IRQ_COALESCE_EN
    chk("t6_pulses", 32'(pulses), 32'd1);
`else
    chk("t6_pulses", 32'(pulses), 32'd3);
`endif
    chk("t6_empty", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
